evr_time_of_day_transmitter: RTL and testbench
==============================================

// Module: evr_time_of_day_transmitter
// PURPOSE
//   Event-generator-side source of the time-of-day protocol consumed by the EVR time-of-day receiver.
//   On each PPS strobe it issues the latch event 0x7D, which commits the previously shifted seconds value.
//   It then increments its seconds register and serialises the new value MSB-first as 0x70 (bit 0) / 0x71 (bit 1) events.
//   Events go to the event-stream mux via a valid/ready slot handshake, so the 32 bits are ready for the next PPS.
// PARAMETERS
//   EVT_ZERO   8'h70  event code for a 0 bit
//   EVT_ONE    8'h71  event code for a 1 bit
//   EVT_LATCH  8'h7D  latch event code
//   GAP        4      idle cycles forced after each accepted event (0..15; 0 = back-to-back)
// PORTS
//   Clock        in   1   system/event clock; all logic on rising edge
//   Reset_n      in   1   asynchronous, active-low reset
//   Enable       in   1   block enable; low = idle, PPS ignored
//   Pps          in   1   single-cycle second-boundary strobe (synchronous to Clock)
//   SecondsIn    in   32  seconds value to load (GPS/NTP)
//   SecondsLoad  in   1   single-cycle strobe: seconds register <= SecondsIn
//   EventCode    out  8   event code offered to the mux (8'h00 when EventValid low)
//   EventValid   out  1   EventCode is offered this cycle
//   EventReady   in   1   mux grants the slot; accept = EventValid & EventReady
//   Busy         out  1   latch/shift sequence in progress
//   Overrun      out  1   one-cycle pulse: Pps arrived before all 32 bits were accepted
//   SecondsOut   out  32  current seconds register (debug)
// BEHAVIOUR
//   Reset (async assert, sync release): EventCode=0, EventValid=0, Busy=0, Overrun=0, SecondsOut=0, state IDLE, bit index=31, gap count=0.
//   All outputs registered. Pps at edge n -> EventValid=1, EventCode=EVT_LATCH at n+1.
//   Handshake: EventCode held stable while EventValid=1 && !EventReady. Valid is withdrawn only on Pps preemption or Enable low.
//   States:
//     IDLE: Busy=0. Pps && Enable -> LATCH.
//     LATCH: offer EVT_LATCH; on accept -> GAP (next=SHIFT).
//     GAP: EventValid=0 for GAP cycles, then -> next. GAP=0 skips directly.
//     SHIFT: offer EVT_ONE/EVT_ZERO for SecondsOut[idx], idx 31 down to 0.
//       On accept: idx==0 -> GAP (next=IDLE); else idx-1 -> GAP (next=SHIFT).
//   Seconds arithmetic: on LATCH acceptance, SecondsOut <= SecondsOut+1 (mod 2^32; 32'hFFFFFFFF wraps to 0).
//     The incremented value is the one shifted. idx reloads to 31 on entry to LATCH.
//   SecondsLoad (any state): SecondsOut <= SecondsIn next cycle.
//     If in SHIFT/GAP(next=SHIFT): restart shift at idx=31 with the new value; no extra latch event.
//     The next Pps then latches SecondsIn+1 -- software loads (current second) so the receiver shows the correct value.
//   Pps while Busy (in SHIFT, or in GAP with next=SHIFT): Overrun=1 for one cycle.
//     The pending bit event is withdrawn; LATCH is entered next cycle and the second boundary is preserved.
//   Pps while in LATCH: ignored (no restart, no Overrun).
//   Pps && SecondsLoad in the same cycle: load SecondsIn, then LATCH. Increment applies to SecondsIn on acceptance.
//   Enable low: -> IDLE next cycle. EventValid=0, Busy=0, idx=31; SecondsOut retained; SecondsLoad still honoured.
//   EventReady stuck low: the offer holds indefinitely. Only Pps, Enable or reset change it.
// TESTING
//   1 Reset: Reset_n low mid-SHIFT with EventValid=1 -> all outputs 0 immediately, IDLE after release.
//   2 Load 32'hA5A5_0000, Pps, EventReady=1, GAP=4 -> 7D, then 71,70,71,70,... (32 events, value 32'hA5A5_0001).
//     Exactly 4 idle cycles between events; Busy drops after the last bit.
//   3 Backpressure: EventReady low 10 cycles during bit 31 -> EventCode/EventValid stable all 10 cycles; no bits skipped.
//   4 Pps at bit index 12 -> Overrun pulse, bit withdrawn, 7D next cycle, new 32-bit shift of incremented value.
//   5 Wrap: load 32'hFFFF_FFFF, Pps -> 7D, then 32 x 70 (value 0).
//   6 Simultaneous Pps+SecondsLoad(32'h0000_0010) -> 7D, then shift of 32'h0000_0011; Enable low mid-shift -> idle next cycle.

Source files
------------

// File: rtl/evr_time_of_day_transmitter.sv
// Time-of-day event source for the EVR: emits a latch event on each PPS, then
// shifts the incremented seconds value MSB-first as zero/one bit events.
module evr_time_of_day_transmitter #(
  parameter logic [7:0]  EVT_ZERO  = 8'h70,
  parameter logic [7:0]  EVT_ONE   = 8'h71,
  parameter logic [7:0]  EVT_LATCH = 8'h7D,
  parameter int unsigned GAP       = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic        Pps,
  input  logic [31:0] SecondsIn,
  input  logic        SecondsLoad,
  output logic [7:0]  EventCode,
  output logic        EventValid,
  input  logic        EventReady,
  output logic        Busy,
  output logic        Overrun,
  output logic [31:0] SecondsOut
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_GAP   = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  localparam bit         GAP_EN   = (GAP != 32'd0);
  localparam logic [3:0] GAP_LAST = GAP_EN ? 4'(GAP - 32'd1) : 4'd0;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] secs_q, secs_d;
  logic [7:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        accept_s;
  state_t      target_s;

  // Next-state, seconds arithmetic and registered-output computation
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    overrun_d = 1'b0;
    target_s  = ST_IDLE;
    accept_s  = valid_q & EventReady;

    if (SecondsLoad) begin
      secs_d = SecondsIn;
    end else if (Enable && state_q == ST_LATCH && accept_s) begin
      secs_d = secs_q + 32'd1;
    end else begin
      secs_d = secs_q;
    end

    if (!Enable) begin
      state_d = ST_IDLE;
      ret_d   = ST_IDLE;
      idx_d   = 5'd31;
      gap_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Pps) begin
            state_d = ST_LATCH;
            idx_d   = 5'd31;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LATCH: begin
          // Pps is deliberately ignored here: the boundary is already being marked
          if (accept_s) begin
            idx_d    = 5'd31;
            target_s = ST_SHIFT;
            if (GAP_EN) begin
              state_d = ST_GAP;
              ret_d   = target_s;
              gap_d   = GAP_LAST;
            end else begin
              state_d = target_s;
            end
          end else begin
            state_d = ST_LATCH;
          end
        end
        ST_GAP: begin
          if (Pps) begin
            overrun_d = (ret_q == ST_SHIFT);
            state_d   = ST_LATCH;
            idx_d     = 5'd31;
          end else begin
            if (SecondsLoad && ret_q == ST_SHIFT) begin
              idx_d = 5'd31;
            end else begin
              idx_d = idx_q;
            end
            if (gap_q == 4'd0) begin
              state_d = ret_q;
            end else begin
              gap_d = gap_q - 4'd1;
            end
          end
        end
        ST_SHIFT: begin
          if (Pps) begin
            overrun_d = 1'b1;
            state_d   = ST_LATCH;
            idx_d     = 5'd31;
          end else if (SecondsLoad) begin
            idx_d = 5'd31;
          end else if (accept_s) begin
            if (idx_q == 5'd0) begin
              target_s = ST_IDLE;
            end else begin
              target_s = ST_SHIFT;
              idx_d    = idx_q - 5'd1;
            end
            if (GAP_EN) begin
              state_d = ST_GAP;
              ret_d   = target_s;
              gap_d   = GAP_LAST;
            end else begin
              state_d = target_s;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ret_d   = ST_IDLE;
          idx_d   = 5'd31;
          gap_d   = 4'd0;
        end
      endcase
    end

    // Outputs are derived from the next state so they appear with the state change
    valid_d = (state_d == ST_LATCH) || (state_d == ST_SHIFT);
    busy_d  = valid_d || (state_d == ST_GAP && ret_d == ST_SHIFT);
    if (!valid_d) begin
      code_d = 8'h00;
    end else if (state_d == ST_LATCH) begin
      code_d = EVT_LATCH;
    end else begin
      code_d = secs_d[idx_d] ? EVT_ONE : EVT_ZERO;
    end
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      idx_q     <= 5'd31;
      gap_q     <= 4'd0;
      secs_q    <= 32'd0;
      code_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      secs_q    <= secs_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign EventCode  = code_q;
  assign EventValid = valid_q;
  assign Busy       = busy_q;
  assign Overrun    = overrun_q;
  assign SecondsOut = secs_q;

endmodule

// File: tb/tb_evr_time_of_day_transmitter.sv
// Directed bench for the time-of-day transmitter: latch/shift sequences,
// backpressure, PPS overrun, wrap, load+PPS, enable drop and async reset.
module tb_evr_time_of_day_transmitter;

  localparam int GAP_CYC = 4;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic        Pps;
  logic [31:0] SecondsIn;
  logic        SecondsLoad;
  logic [7:0]  EventCode;
  logic        EventValid;
  logic        EventReady;
  logic        Busy;
  logic        Overrun;
  logic [31:0] SecondsOut;

  int tests_run    = 0;
  int tests_failed = 0;

  evr_time_of_day_transmitter #(.GAP(GAP_CYC)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Pps(Pps),
    .SecondsIn(SecondsIn), .SecondsLoad(SecondsLoad),
    .EventCode(EventCode), .EventValid(EventValid), .EventReady(EventReady),
    .Busy(Busy), .Overrun(Overrun), .SecondsOut(SecondsOut)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for the next offered event, checks the idle gap before it and its code
  task automatic next_event(input string tag, input logic [7:0] exp_code);
    int idle;
    idle = 0;
    @(negedge Clock);
    while (!EventValid && idle < 40) begin
      idle++;
      @(negedge Clock);
    end
    check_eq({tag, "_gap"}, idle, GAP_CYC);
    check_eq(tag, {24'd0, EventCode}, {24'd0, exp_code});
  endtask

  task automatic shift_range(input logic [31:0] val, input int hi, input int lo);
    for (int i = hi; i >= lo; i--)
      next_event($sformatf("bit%0d", i), val[i] ? 8'h71 : 8'h70);
  endtask

  task automatic start_latch();
    Pps = 1'b1;
    @(negedge Clock);
    Pps = 1'b0;
    check_eq("latch_valid", {31'd0, EventValid}, 32'd1);
    check_eq("latch_code", {24'd0, EventCode}, 32'h7D);
    check_eq("latch_busy", {31'd0, Busy}, 32'd1);
  endtask

  task automatic end_seq(input logic [31:0] val);
    @(negedge Clock);
    check_eq("end_busy", {31'd0, Busy}, 32'd0);
    check_eq("end_valid", {31'd0, EventValid}, 32'd0);
    check_eq("end_overrun", {31'd0, Overrun}, 32'd0);
    check_eq("end_secs", SecondsOut, val);
    repeat (5) @(negedge Clock);
  endtask

  task automatic load_secs(input logic [31:0] val);
    SecondsIn   = val;
    SecondsLoad = 1'b1;
    @(negedge Clock);
    SecondsLoad = 1'b0;
    check_eq("load_secs", SecondsOut, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Enable = 1'b1; Pps = 1'b0; SecondsIn = 32'd0;
    SecondsLoad = 1'b0; EventReady = 1'b1;
    #1;
    check_eq("rst_valid", {31'd0, EventValid}, 32'd0);
    check_eq("rst_code", {24'd0, EventCode}, 32'd0);
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_overrun", {31'd0, Overrun}, 32'd0);
    check_eq("rst_secs", SecondsOut, 32'd0);
    @(negedge Clock); @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    check_eq("idle_valid", {31'd0, EventValid}, 32'd0);

    // Basic sequence with alternating bit pattern
    load_secs(32'hA5A5_0000);
    start_latch();
    shift_range(32'hA5A5_0001, 31, 0);
    end_seq(32'hA5A5_0001);

    // Backpressure on bit 31
    start_latch();
    next_event("bp_bit31", 8'h71);
    EventReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      check_eq("bp_valid", {31'd0, EventValid}, 32'd1);
      check_eq("bp_code", {24'd0, EventCode}, 32'h71);
    end
    EventReady = 1'b1;
    shift_range(32'hA5A5_0002, 30, 0);
    end_seq(32'hA5A5_0002);

    // Pps while bit 12 is offered
    start_latch();
    shift_range(32'hA5A5_0003, 31, 12);
    Pps = 1'b1;
    @(negedge Clock);
    Pps = 1'b0;
    check_eq("ovr_pulse", {31'd0, Overrun}, 32'd1);
    check_eq("ovr_valid", {31'd0, EventValid}, 32'd1);
    check_eq("ovr_code", {24'd0, EventCode}, 32'h7D);
    check_eq("ovr_secs", SecondsOut, 32'hA5A5_0003);
    shift_range(32'hA5A5_0004, 31, 0);
    end_seq(32'hA5A5_0004);

    // Wrap from all ones
    load_secs(32'hFFFF_FFFF);
    start_latch();
    shift_range(32'h0000_0000, 31, 0);
    end_seq(32'h0000_0000);

    // Simultaneous load and Pps, then Enable drop mid-shift
    SecondsIn = 32'h0000_0010; SecondsLoad = 1'b1; Pps = 1'b1;
    @(negedge Clock);
    SecondsLoad = 1'b0; Pps = 1'b0;
    check_eq("lp_code", {24'd0, EventCode}, 32'h7D);
    check_eq("lp_valid", {31'd0, EventValid}, 32'd1);
    check_eq("lp_secs", SecondsOut, 32'h0000_0010);
    shift_range(32'h0000_0011, 31, 20);
    Enable = 1'b0;
    @(negedge Clock);
    check_eq("en_valid", {31'd0, EventValid}, 32'd0);
    check_eq("en_code", {24'd0, EventCode}, 32'd0);
    check_eq("en_busy", {31'd0, Busy}, 32'd0);
    check_eq("en_secs", SecondsOut, 32'h0000_0011);
    Enable = 1'b1;
    @(negedge Clock);

    // Async reset while a bit is being offered
    start_latch();
    shift_range(32'h0000_0012, 31, 28);
    Reset_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, EventValid}, 32'd0);
    check_eq("arst_code", {24'd0, EventCode}, 32'd0);
    check_eq("arst_busy", {31'd0, Busy}, 32'd0);
    check_eq("arst_secs", SecondsOut, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    check_eq("post_rst_valid", {31'd0, EventValid}, 32'd0);
    check_eq("post_rst_busy", {31'd0, Busy}, 32'd0);
    start_latch();
    shift_range(32'h0000_0001, 31, 0);
    end_seq(32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
